pc_seq_ctrl: RTL and testbench
==============================

// Module: pc_seq_ctrl
// PURPOSE
//  Next-PC sequencer for the PC register. Each cycle it computes pc_en/pc_din from the
//  branch, jump, stall, halt and (optionally) exception inputs. It buffers any redirect
//  that arrives during a pipeline stall and counts PC advances.
//  Sits between the hazard/branch logic and the PC register; pc_q is fed back from it.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  restart address driven on pc_din while rst is high
//  EXC_VEC    32'h0000_4180  exception entry address (used only with PC_EXC_EN)
//  CNT_W      32             width of the PC-advance counter
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      reset, asynchronous, active-high
//  pc_q           in   32     current PC register value
//  stall          in   1      pipeline stall; PC must hold
//  br_taken       in   1      conditional branch resolved taken
//  br_target      in   32     branch target
//  jmp            in   1      unconditional jump
//  jmp_target     in   32     jump target
//  halt_req       in   1      halt/syscall request
//  resume         in   1      leave HALT
//  exc_req        in   1      exception request (PC_EXC_EN)
//  eret           in   1      return from exception (PC_EXC_EN)
//  pc_en          out  1      PC register load enable (combinational)
//  pc_din         out  32     next PC value (combinational)
//  halted         out  1      high in HALT
//  redirect_pend  out  1      a buffered redirect is waiting for stall release
//  adv_cnt        out  CNT_W  number of cycles with pc_en=1
//  epc            out  32     saved exception PC (PC_EXC_EN; otherwise tied 0)
// BEHAVIOUR
//  - Reset: state=RUN, pend_vld=0, pend_addr=0, pend_exc=0, adv_cnt=0, epc=0, halted=0.
//    While rst is high: pc_en=0 and pc_din=RESET_VEC.
//  - Target selection priority: exc_req > eret > jmp > br_taken > pc_q+4.
//    pc_q+4 is mod 2^32, so 0xFFFF_FFFC wraps to 0. Bits [1:0] of every target are forced to 0.
//  - FSM states: RUN, STALL, HALT. State, pending buffer and counters are registered.
//    pc_en and pc_din are combinational from state, buffer and inputs. Redirect latency is 0 cycles.
//  - RUN, stall=0, halt_req=0: pc_en=1, pc_din=selected target.
//  - RUN, stall=1: pc_en=0. If any redirect is asserted, capture it into pend_addr,
//    set pend_vld=1, and set pend_exc=1 if the redirect is exc_req. Next state=STALL.
//  - STALL, stall=1: pc_en=0. A new redirect overwrites the buffer (latest wins), except
//    that a buffered exception is only replaced by another exc_req.
//  - STALL, stall=0: if pend_vld=1, pc_din=pend_addr; otherwise pc_din=selected target
//    (same-cycle redirect inputs obey normal priority, and a buffered exception still
//    beats them). pc_en=1, pend_vld and pend_exc clear, next state=RUN.
//  - stall has priority over halt_req. halt_req with stall=0 in RUN or STALL gives pc_en=0
//    (PC stays on the halting instruction), discards any buffered redirect, next state=HALT.
//  - HALT: pc_en=0, halted=1. Redirect inputs are ignored.
//    resume=1 -> RUN next cycle; PC advances on the following cycle as normal.
//  - redirect_pend = pend_vld.
//  - adv_cnt increments on every clock edge where pc_en=1. It wraps from all-ones to 0.
//  - rst asserted mid-operation aborts every state immediately and discards any pending redirect.
// CONFIGURATION
//  PC_EXC_EN defined:
//   - exc_req/eret are active. Accepting an exception (the cycle pc_en=1 with pc_din=EXC_VEC)
//     loads epc<=pc_q. eret redirects to epc.
//   - exc_req in HALT forces pc_din=EXC_VEC, pc_en=1, epc<=pc_q, next state=RUN.
//  PC_EXC_EN undefined:
//   - exc_req/eret are ignored and epc=0. Priority is jmp > br_taken > pc_q+4.
// TESTING
//  1 Reset then 4 free-run cycles with pc_q fed back -> pc 0,4,8,C,10; adv_cnt=4.
//  2 pc_q=0x40, jmp=1 with target 0x103 and br_taken=1 with target 0x200 -> pc_din=0x100, pc_en=1.
//  3 pc_q=0x40, stall=1 for 3 cycles, br_taken=1 only in cycle 1 with target 0x80
//    -> pc_en=0 for 3 cycles, redirect_pend=1; release -> pc_din=0x80, pend clears.
//  4 halt_req at pc_q=0x20 -> pc_en=0, halted=1 for 5 cycles with br_taken toggling;
//    resume -> next-next cycle pc_din=0x24.
//  5 (PC_EXC_EN) exc_req at pc_q=0x60 -> pc_din=0x4180, epc=0x60; later eret -> pc_din=0x60.
//  6 pc_q=0xFFFF_FFFC free-run -> pc_din=0; pulse rst during STALL with pend_vld=1
//    -> pend cleared, state RUN; with adv_cnt preloaded to all-ones via run, next advance gives 0.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer feeding the PC register.
//   Chooses pc_en/pc_din each cycle from stall, halt, jump, branch and
//   (optionally) exception inputs. A redirect seen while the pipe is stalled
//   is parked in a one-entry buffer and issued on stall release. Counts every
//   cycle the PC register loads.
// Build option: define PC_EXC_EN to enable exc_req/eret and the epc register.
//   Without it, exc_req/eret are ignored and epc reads 0.
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   pc_q              current PC register value (feedback)
//   stall             pipeline stall, PC holds
//   br_taken/br_target, jmp/jmp_target   redirect requests
//   halt_req, resume  enter / leave HALT
//   exc_req, eret     exception entry / return (PC_EXC_EN)
//   pc_en, pc_din     combinational PC load enable and next value
//   halted            high while in HALT
//   redirect_pend     a buffered redirect waits for stall release
//   adv_cnt           count of cycles with pc_en=1 (wraps)
//   epc               saved exception PC
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_q,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp,
    input  logic [31:0]      jmp_target,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             exc_req,
    input  logic             eret,
    output logic             pc_en,
    output logic [31:0]      pc_din,
    output logic             halted,
    output logic             redirect_pend,
    output logic [CNT_W-1:0] adv_cnt,
    output logic [31:0]      epc
);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    // One-entry redirect buffer; exc marks an exception entry that only a
    // newer exception may replace.
    typedef struct packed {
        logic        vld;
        logic        exc;
        logic [31:0] addr;
    } pend_t;

    state_t      state;
    pend_t       pend;
    logic        exc_act;
    logic        eret_act;
    logic        redir_any;
    logic        exc_take;   // this cycle's PC load is an exception entry
    logic [31:0] sel;
    logic [31:0] epc_r;

`ifdef PC_EXC_EN
    assign exc_act  = exc_req;
    assign eret_act = eret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            epc_r <= '0;
        else if (exc_take)
            epc_r <= pc_q;
    end
`else
    logic unused_exc;
    assign unused_exc = exc_req ^ eret ^ exc_take;
    assign exc_act    = 1'b0;
    assign eret_act   = 1'b0;
    assign epc_r      = '0;
`endif

    assign redir_any     = exc_act | eret_act | jmp | br_taken;
    assign redirect_pend = pend.vld;
    assign epc           = epc_r;

    // Target priority: exception > eret > jump > branch > sequential.
    always_comb begin
        sel = pc_q + 32'd4;
        if (br_taken) sel = br_target;
        if (jmp)      sel = jmp_target;
        if (eret_act) sel = epc_r;
        if (exc_act)  sel = EXC_VEC;
        sel[1:0] = 2'b00;
    end

    always_comb begin
        pc_en    = 1'b0;
        pc_din   = sel;
        exc_take = 1'b0;
        if (rst) begin
            pc_din = RESET_VEC;
        end else begin
            case (state)
                RUN, STALL: begin
                    if (!stall && !halt_req) begin
                        pc_en = 1'b1;
                        // A parked redirect (RUN never holds one) beats
                        // anything arriving this cycle.
                        if (pend.vld) begin
                            pc_din   = pend.addr;
                            exc_take = pend.exc;
                        end else begin
                            exc_take = exc_act;
                        end
                    end
                end
                HALT: begin
                    if (exc_act) begin
                        pc_en    = 1'b1;
                        exc_take = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pend    <= '0;
            adv_cnt <= '0;
            halted  <= 1'b0;
        end else begin
            if (pc_en)
                adv_cnt <= adv_cnt + CNT_W'(1);
            case (state)
                RUN, STALL: begin
                    if (stall) begin
                        state <= STALL;
                        if (redir_any && (!pend.exc || exc_act))
                            pend <= '{vld: 1'b1, exc: exc_act, addr: sel};
                    end else begin
                        pend <= '0;
                        if (halt_req) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                HALT: begin
                    if (exc_act || resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model built from a halt flag
// and a queue holding at most one parked redirect.
module tb_pc_seq_ctrl;

    localparam int          CNT_W = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0000;
    localparam logic [31:0] EVEC  = 32'h0000_4180;
`ifdef PC_EXC_EN
    localparam bit EXC_ON = 1'b1;
`else
    localparam bit EXC_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pc_q;
    logic             stall, br_taken, jmp, halt_req, resume, exc_req, eret;
    logic [31:0]      br_target, jmp_target;
    logic             pc_en, halted, redirect_pend;
    logic [31:0]      pc_din, epc;
    logic [CNT_W-1:0] adv_cnt;

    pc_seq_ctrl #(.RESET_VEC(RVEC), .EXC_VEC(EVEC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pc_q(pc_q), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target),
        .halt_req(halt_req), .resume(resume),
        .exc_req(exc_req), .eret(eret),
        .pc_en(pc_en), .pc_din(pc_din), .halted(halted),
        .redirect_pend(redirect_pend), .adv_cnt(adv_cnt), .epc(epc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    bit          m_halt;
    logic [32:0] pendq[$];   // {is_exception, address}
    logic [31:0] m_cnt;
    logic [31:0] m_epc;
    logic [31:0] pcr;        // bench-side PC register
    logic        o_en;
    logic [31:0] o_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        stall = 0; br_taken = 0; jmp = 0; halt_req = 0; resume = 0;
        exc_req = 0; eret = 0;
        br_target = '0; jmp_target = '0;
    endtask

    task automatic m_reset();
        m_halt = 0; pendq.delete(); m_cnt = '0; m_epc = '0; pcr = RVEC;
    endtask

    // Called just after a falling edge with inputs set; checks, then advances
    // model and DUT by one rising edge and returns at the next falling edge.
    task automatic cyc();
        logic        ex, er, en, acc;
        logic [31:0] tgt, din;
        pc_q = pcr;
        #1;
        if (rst) m_reset();
        ex = EXC_ON && exc_req;
        er = EXC_ON && eret;
        tgt = ex ? EVEC : er ? m_epc : jmp ? jmp_target : br_taken ? br_target : pcr + 32'd4;
        tgt = tgt & 32'hFFFF_FFFC;
        en = 0; din = tgt;
        if (rst)                      din = RVEC;
        else if (m_halt)              en = ex;
        else if (!stall && !halt_req) begin
            en = 1;
            if (pendq.size() != 0) din = pendq[0][31:0];
        end
        acc = en && (m_halt ? ex : (pendq.size() != 0 ? pendq[0][32] : ex));
        o_en = pc_en; o_din = pc_din;
        chk("pc_en", 32'(pc_en), 32'(en));
        if (en || rst) chk("pc_din", pc_din, din);
        chk("halted", 32'(halted), 32'(m_halt));
        chk("redirect_pend", 32'(redirect_pend), 32'(pendq.size() != 0));
        chk("adv_cnt", 32'(adv_cnt), m_cnt);
        chk("epc", epc, m_epc);
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (en) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                pcr = din;
            end
            if (acc) m_epc = pc_q;
            if (m_halt) begin
                if (ex || resume) m_halt = 0;
            end else if (stall) begin
                if ((ex || er || jmp || br_taken) &&
                    (pendq.size() == 0 || !pendq[0][32] || ex)) begin
                    pendq.delete();
                    pendq.push_back({ex, tgt});
                end
            end else begin
                pendq.delete();
                if (halt_req) m_halt = 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clr_in();
        m_reset();
        rst = 1;
        pc_q = '0;
        @(negedge clk);
        cyc();                       // reset state and reset-vector output
        rst = 0;

        // 1: free run from reset
        repeat (4) cyc();
        chk("t1_pc", pcr, 32'h10);
        chk("t1_cnt", 32'(adv_cnt), 32'd4);

        // 2: jump beats branch, low bits cleared
        pcr = 32'h40; jmp = 1; jmp_target = 32'h103; br_taken = 1; br_target = 32'h200;
        cyc();
        chk("t2_din", o_din, 32'h100);
        chk("t2_en", 32'(o_en), 32'd1);
        clr_in();

        // 3: branch arriving during a stall is parked until release
        pcr = 32'h40; stall = 1; br_taken = 1; br_target = 32'h80;
        cyc();
        br_taken = 0;
        cyc(); cyc();
        chk("t3_pend", 32'(redirect_pend), 32'd1);
        chk("t3_hold", 32'(o_en), 32'd0);
        stall = 0;
        cyc();
        chk("t3_din", o_din, 32'h80);
        chk("t3_clr", 32'(redirect_pend), 32'd0);

        // 4: halt, ignore branches, resume
        pcr = 32'h20; halt_req = 1;
        cyc();
        chk("t4_en", 32'(o_en), 32'd0);
        halt_req = 0;
        for (int i = 0; i < 5; i++) begin
            br_taken = i[0]; br_target = 32'h300;
            cyc();
            chk("t4_halted", 32'(halted), 32'd1);
        end
        br_taken = 0; resume = 1;
        cyc();
        resume = 0;
        cyc();
        chk("t4_din", o_din, 32'h24);

        // 5: exception entry and return
        pcr = 32'h60; exc_req = 1;
        cyc();
        exc_req = 0;
        if (EXC_ON) begin
            chk("t5_din", o_din, 32'h4180);
            chk("t5_epc", epc, 32'h60);
            cyc();
            eret = 1;
            cyc();
            eret = 0;
            chk("t5_eret", o_din, 32'h60);
        end else begin
            chk("t5_ign", o_din, 32'h64);
            chk("t5_epc0", epc, 32'h0);
        end

        // 6: wrap of pc+4, reset during a parked redirect, counter wrap
        pcr = 32'hFFFF_FFFC;
        cyc();
        chk("t6_wrap", o_din, 32'h0);
        stall = 1; jmp = 1; jmp_target = 32'h500;
        cyc();
        jmp = 0;
        rst = 1;
        cyc();
        rst = 0; stall = 0;
        chk("t6_pend", 32'(redirect_pend), 32'd0);
        repeat (15) cyc();
        chk("t6_full", 32'(adv_cnt), 32'hF);
        cyc();
        chk("t6_cnt0", 32'(adv_cnt), 32'h0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            stall      = ($urandom_range(99) < 30);
            halt_req   = ($urandom_range(99) < 6);
            resume     = ($urandom_range(99) < 30);
            br_taken   = ($urandom_range(99) < 30);
            jmp        = ($urandom_range(99) < 15);
            exc_req    = ($urandom_range(99) < 6);
            eret       = ($urandom_range(99) < 6);
            br_target  = $urandom;
            jmp_target = $urandom;
            rst        = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 10) pcr = $urandom;
            cyc();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
